// File: rtl/sr_wb_arbiter_if.sv
// Bus bundle between the execute/writeback pipeline and the SR write arbiter.
//   master : drives the WB write, the aux write and the two read indices,
//            receives read data, PSTATE, stall, occupancy and read hazard.
//   slave  : the arbiter side of the same signals.
interface sr_wb_arbiter_if #(
   parameter int SR_W  = 48,
   parameter int SR_N  = 4,
   parameter int DEPTH = 2
);
   localparam int AW = $clog2(SR_N);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            iw_wb_we;
   logic [AW-1:0]   iw_wb_addr;
   logic [SR_W-1:0] iw_wb_data;
   logic            iw_aux_we;
   logic [AW-1:0]   iw_aux_addr;
   logic [SR_W-1:0] iw_aux_data;
   logic [AW-1:0]   iw_rd_a_addr;
   logic [SR_W-1:0] ow_rd_a_data;
   logic [AW-1:0]   iw_rd_b_addr;
   logic [SR_W-1:0] ow_rd_b_data;
   logic [SR_W-1:0] ow_pstate;
   logic            ow_aux_stall;
   logic [CW-1:0]   ow_count;
   logic            ow_read_hazard;

   modport master (
      output iw_wb_we, iw_wb_addr, iw_wb_data,
      output iw_aux_we, iw_aux_addr, iw_aux_data,
      output iw_rd_a_addr, iw_rd_b_addr,
      input  ow_rd_a_data, ow_rd_b_data, ow_pstate,
      input  ow_aux_stall, ow_count, ow_read_hazard
   );

   modport slave (
      input  iw_wb_we, iw_wb_addr, iw_wb_data,
      input  iw_aux_we, iw_aux_addr, iw_aux_data,
      input  iw_rd_a_addr, iw_rd_b_addr,
      output ow_rd_a_data, ow_rd_b_data, ow_pstate,
      output ow_aux_stall, ow_count, ow_read_hazard
   );
endinterface

// File: rtl/sr_wb_arbiter.sv
// Write-side owner of the special-register file. Merges the committed WB
// write with the auxiliary SR/PSTATE write from stg_ex. WB always wins the
// single write port; aux writes that collide with WB (or with older queued
// aux writes) wait in a small ordered FIFO and drain on WB-idle cycles.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sr_wb_arbiter_if.slave (WB write, aux write, two read ports,
//              PSTATE, aux stall, FIFO occupancy, read hazard)
//
// Build option SR_WB_BYPASS_EN:
//   defined   - reads forward the newest pending value (aux > FIFO > WB > sr),
//               ow_read_hazard is tied 0.
//   undefined - reads return sr[] only; ow_read_hazard flags any read index
//               (A, B or PSTATE) that has a pending write in flight.
module sr_wb_arbiter #(
   parameter int SR_W       = 48,
   parameter int SR_N       = 4,
   parameter int DEPTH      = 2,
   parameter int PSTATE_IDX = 2
) (
   input logic            clk,
   input logic            rst,
   sr_wb_arbiter_if.slave bus
);
   localparam int AW = $clog2(SR_N);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   localparam logic [AW-1:0] PS_ADDR = AW'(PSTATE_IDX);

   logic [SR_W-1:0] sr     [SR_N];
   logic [AW-1:0]   q_addr [DEPTH];
   logic [SR_W-1:0] q_data [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count;

   logic stall;
   logic aux_acc;
   logic drain;
   logic direct;
   logic enq;

   // Stall is based on the registered count only: a slot freed by a drain
   // this cycle becomes usable on the next cycle.
   assign stall   = (count == CW'(DEPTH));
   assign aux_acc = bus.iw_aux_we && !stall;
   assign drain   = !bus.iw_wb_we && (count != '0);
   // With nothing queued and WB idle, the aux write can take the port now.
   assign direct  = aux_acc && !bus.iw_wb_we && (count == '0);
   assign enq     = aux_acc && !direct;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SR_N; i++) sr[i] <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_addr[i] <= '0;
            q_data[i] <= '0;
         end
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (bus.iw_wb_we)
            sr[bus.iw_wb_addr] <= bus.iw_wb_data;
         else if (drain)
            sr[q_addr[head]] <= q_data[head];
         else if (direct)
            sr[bus.iw_aux_addr] <= bus.iw_aux_data;

         if (drain)
            head <= head + 1'b1;

         if (enq) begin
            q_addr[tail] <= bus.iw_aux_addr;
            q_data[tail] <= bus.iw_aux_data;
            tail         <= tail + 1'b1;
         end

         count <= count + CW'(enq) - CW'(drain);
      end
   end

   assign bus.ow_aux_stall = stall;
   assign bus.ow_count     = count;

`ifdef SR_WB_BYPASS_EN
   // Newest value wins. Sources are layered oldest to youngest so that the
   // last match overrides: sr, WB this cycle, FIFO head..tail, accepted aux.
   function automatic logic [SR_W-1:0] fwd_read(input logic [AW-1:0] a);
      logic [SR_W-1:0] v;
      logic [PW-1:0]   slot;
      v = sr[a];
      if (bus.iw_wb_we && (bus.iw_wb_addr == a))
         v = bus.iw_wb_data;
      for (int i = 0; i < DEPTH; i++) begin
         slot = head + PW'(i);
         if ((i < int'(count)) && (q_addr[slot] == a))
            v = q_data[slot];
      end
      if (aux_acc && (bus.iw_aux_addr == a))
         v = bus.iw_aux_data;
      return v;
   endfunction

   always_comb begin
      bus.ow_rd_a_data   = fwd_read(bus.iw_rd_a_addr);
      bus.ow_rd_b_data   = fwd_read(bus.iw_rd_b_addr);
      bus.ow_pstate      = fwd_read(PS_ADDR);
      bus.ow_read_hazard = 1'b0;
   end
`else
   function automatic logic pending(input logic [AW-1:0] a);
      logic          hit;
      logic [PW-1:0] slot;
      hit = (bus.iw_wb_we && (bus.iw_wb_addr == a)) ||
            (aux_acc && (bus.iw_aux_addr == a));
      for (int i = 0; i < DEPTH; i++) begin
         slot = head + PW'(i);
         if ((i < int'(count)) && (q_addr[slot] == a))
            hit = 1'b1;
      end
      return hit;
   endfunction

   always_comb begin
      bus.ow_rd_a_data   = sr[bus.iw_rd_a_addr];
      bus.ow_rd_b_data   = sr[bus.iw_rd_b_addr];
      bus.ow_pstate      = sr[PS_ADDR];
      bus.ow_read_hazard = pending(bus.iw_rd_a_addr) ||
                           pending(bus.iw_rd_b_addr) ||
                           pending(PS_ADDR);
   end
`endif

endmodule

// File: tb/tb_sr_wb_arbiter.sv
// Bench for sr_wb_arbiter. A write-log model (register array plus an ordered
// queue of pending aux writes) predicts every output on each falling edge;
// directed sequences add hand-computed literal checks on top.
module tb_sr_wb_arbiter;
   localparam int SR_W       = 48;
   localparam int SR_N       = 4;
   localparam int DEPTH      = 2;
   localparam int PSTATE_IDX = 2;
   localparam int AW         = $clog2(SR_N);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sr_wb_arbiter_if #(.SR_W(SR_W), .SR_N(SR_N), .DEPTH(DEPTH)) bus ();

   sr_wb_arbiter #(
      .SR_W(SR_W), .SR_N(SR_N), .DEPTH(DEPTH), .PSTATE_IDX(PSTATE_IDX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int compared   = 0;
   int mismatched = 0;

   task automatic chk(input string name, input logic [SR_W-1:0] act,
                      input logic [SR_W-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   typedef struct packed {
      logic [AW-1:0]   a;
      logic [SR_W-1:0] d;
   } wr_t;

   logic [SR_W-1:0] m_sr [SR_N];
   wr_t             m_q  [$];

   function automatic bit m_aux_ok();
      return bus.iw_aux_we && (m_q.size() < DEPTH);
   endfunction

   // Value a reader would see if every in-flight write had already landed.
   function automatic logic [SR_W-1:0] newest(input logic [AW-1:0] a);
      logic [SR_W-1:0] v;
      v = m_sr[a];
      if (bus.iw_wb_we && bus.iw_wb_addr == a) v = bus.iw_wb_data;
      foreach (m_q[i]) if (m_q[i].a == a) v = m_q[i].d;
      if (m_aux_ok() && bus.iw_aux_addr == a) v = bus.iw_aux_data;
      return v;
   endfunction

   function automatic bit in_flight(input logic [AW-1:0] a);
      bit h;
      h = (bus.iw_wb_we && bus.iw_wb_addr == a) ||
          (m_aux_ok() && bus.iw_aux_addr == a);
      foreach (m_q[i]) if (m_q[i].a == a) h = 1'b1;
      return h;
   endfunction

   function automatic logic [SR_W-1:0] exp_rd(input logic [AW-1:0] a);
`ifdef SR_WB_BYPASS_EN
      return newest(a);
`else
      return m_sr[a];
`endif
   endfunction

   function automatic logic exp_hazard();
`ifdef SR_WB_BYPASS_EN
      return 1'b0;
`else
      return in_flight(bus.iw_rd_a_addr) || in_flight(bus.iw_rd_b_addr) ||
             in_flight(AW'(PSTATE_IDX));
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         foreach (m_sr[i]) m_sr[i] = '0;
         m_q.delete();
      end else begin
         bit  acc, was_empty;
         wr_t h;
         acc       = m_aux_ok();
         was_empty = (m_q.size() == 0);
         if (bus.iw_wb_we) begin
            m_sr[bus.iw_wb_addr] = bus.iw_wb_data;
         end else if (!was_empty) begin
            h = m_q.pop_front();
            m_sr[h.a] = h.d;
         end
         if (acc) begin
            if (!bus.iw_wb_we && was_empty)
               m_sr[bus.iw_aux_addr] = bus.iw_aux_data;
            else
               m_q.push_back('{a: bus.iw_aux_addr, d: bus.iw_aux_data});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("rd_a", bus.ow_rd_a_data, exp_rd(bus.iw_rd_a_addr));
         chk("rd_b", bus.ow_rd_b_data, exp_rd(bus.iw_rd_b_addr));
         chk("pstate", bus.ow_pstate, exp_rd(AW'(PSTATE_IDX)));
         chk("stall", SR_W'(bus.ow_aux_stall), SR_W'(m_q.size() == DEPTH));
         chk("count", SR_W'(bus.ow_count), SR_W'(m_q.size()));
         chk("hazard", SR_W'(bus.ow_read_hazard), SR_W'(exp_hazard()));
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic wwe, input logic [AW-1:0] wa,
                        input logic [SR_W-1:0] wd, input logic awe,
                        input logic [AW-1:0] aa, input logic [SR_W-1:0] ad);
      bus.iw_wb_we    = wwe;
      bus.iw_wb_addr  = wa;
      bus.iw_wb_data  = wd;
      bus.iw_aux_we   = awe;
      bus.iw_aux_addr = aa;
      bus.iw_aux_data = ad;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      bus.iw_rd_a_addr = '0;
      bus.iw_rd_b_addr = '0;
      #12 rst = 1'b0;
      tick();

      // reset state: every index reads zero
      for (int i = 0; i < SR_N; i++) begin
         bus.iw_rd_a_addr = AW'(i);
         bus.iw_rd_b_addr = AW'(SR_N - 1 - i);
         #1;
         chk("rst_rd_a", bus.ow_rd_a_data, '0);
         chk("rst_rd_b", bus.ow_rd_b_data, '0);
         tick();
      end
      chk("rst_pstate", bus.ow_pstate, '0);
      chk("rst_count", SR_W'(bus.ow_count), '0);
      chk("rst_stall", SR_W'(bus.ow_aux_stall), '0);
      chk("rst_hazard", SR_W'(bus.ow_read_hazard), '0);

      // aux-only write straight into sr[2]
      bus.iw_rd_a_addr = 2'd2;
      bus.iw_rd_b_addr = 2'd0;
      drive(1'b0, '0, '0, 1'b1, 2'd2, 48'h9);
      #1;
`ifdef SR_WB_BYPASS_EN
      chk("aux_fwd_pstate", bus.ow_pstate, 48'h9);
`else
      chk("aux_nofwd_pstate", bus.ow_pstate, 48'h0);
      chk("aux_hazard", SR_W'(bus.ow_read_hazard), 48'h1);
`endif
      chk("aux_count", SR_W'(bus.ow_count), '0);
      tick();
      idle();
      #1;
      chk("aux_sr2", bus.ow_rd_a_data, 48'h9);
      chk("aux_count_after", SR_W'(bus.ow_count), '0);

      // WB and aux to the same index: WB lands first, aux drains over it
      drive(1'b1, 2'd2, 48'h1, 1'b1, 2'd2, 48'h8);
      tick();
      idle();
      #1;
      chk("coll_count", SR_W'(bus.ow_count), 48'h1);
`ifdef SR_WB_BYPASS_EN
      chk("coll_pstate_fwd", bus.ow_pstate, 48'h8);
`else
      chk("coll_pstate_sr", bus.ow_pstate, 48'h1);
      chk("coll_hazard", SR_W'(bus.ow_read_hazard), 48'h1);
`endif
      tick();
      chk("coll_drained", bus.ow_pstate, 48'h8);
      chk("coll_count0", SR_W'(bus.ow_count), '0);

      // WB busy three cycles while aux writes idx0 = 1, 2, 3
      bus.iw_rd_a_addr = 2'd0;
      bus.iw_rd_b_addr = 2'd3;
      drive(1'b1, 2'd3, 48'hA, 1'b1, 2'd0, 48'h1);
      tick();
      chk("fill_count1", SR_W'(bus.ow_count), 48'h1);
      drive(1'b1, 2'd3, 48'hB, 1'b1, 2'd0, 48'h2);
      tick();
      chk("fill_count2", SR_W'(bus.ow_count), 48'h2);
      chk("fill_stall", SR_W'(bus.ow_aux_stall), 48'h1);
      drive(1'b1, 2'd3, 48'hC, 1'b1, 2'd0, 48'h3);
      #1;
      chk("held_stall", SR_W'(bus.ow_aux_stall), 48'h1);
      tick();
      chk("held_count", SR_W'(bus.ow_count), 48'h2);
      drive(1'b0, '0, '0, 1'b1, 2'd0, 48'h3);
      #1;
      chk("drain_stall", SR_W'(bus.ow_aux_stall), 48'h1);
      tick();
      chk("drain_count", SR_W'(bus.ow_count), 48'h1);
      tick();
      idle();
      #1;
      chk("swap_count", SR_W'(bus.ow_count), 48'h1);
`ifdef SR_WB_BYPASS_EN
      chk("swap_rd_a", bus.ow_rd_a_data, 48'h3);
`else
      chk("swap_rd_a", bus.ow_rd_a_data, 48'h2);
`endif
      tick();
      chk("order_sr0", bus.ow_rd_a_data, 48'h3);
      chk("order_sr3", bus.ow_rd_b_data, 48'hC);
      chk("order_count", SR_W'(bus.ow_count), '0);

      // drain and enqueue on the same edge at count=1 (pointers wrap)
      bus.iw_rd_a_addr = 2'd1;
      bus.iw_rd_b_addr = 2'd3;
      drive(1'b1, 2'd1, 48'h5, 1'b1, 2'd1, 48'h11);
      tick();
      drive(1'b0, '0, '0, 1'b1, 2'd3, 48'h33);
      #1;
      chk("wrap_count_pre", SR_W'(bus.ow_count), 48'h1);
      tick();
      idle();
      #1;
      chk("wrap_count_mid", SR_W'(bus.ow_count), 48'h1);
      chk("wrap_head_sr1", bus.ow_rd_a_data, 48'h11);
      tick();
      chk("wrap_count_end", SR_W'(bus.ow_count), '0);
      chk("wrap_sr3", bus.ow_rd_b_data, 48'h33);

      // pending FIFO entry for idx1 seen by read port A
      bus.iw_rd_a_addr = 2'd1;
      bus.iw_rd_b_addr = 2'd0;
      drive(1'b1, 2'd0, 48'h44, 1'b1, 2'd1, 48'h77);
      tick();
      idle();
      #1;
`ifdef SR_WB_BYPASS_EN
      chk("pend_hazard", SR_W'(bus.ow_read_hazard), '0);
      chk("pend_rd_a", bus.ow_rd_a_data, 48'h77);
`else
      chk("pend_hazard", SR_W'(bus.ow_read_hazard), 48'h1);
      chk("pend_rd_a", bus.ow_rd_a_data, 48'h11);
`endif
      tick();
      chk("pend_clear", SR_W'(bus.ow_read_hazard), '0);
      chk("pend_sr1", bus.ow_rd_a_data, 48'h77);
      chk("pend_sr0", bus.ow_rd_b_data, 48'h44);

      // reset with two entries queued discards them
      bus.iw_rd_a_addr = 2'd3;
      drive(1'b1, 2'd3, 48'h99, 1'b1, 2'd0, 48'h55);
      tick();
      drive(1'b1, 2'd3, 48'h98, 1'b1, 2'd1, 48'h66);
      tick();
      idle();
      #1;
      chk("prerst_count", SR_W'(bus.ow_count), 48'h2);
      #2 rst = 1'b1;
      #1;
      chk("midrst_count", SR_W'(bus.ow_count), '0);
      chk("midrst_rd_a", bus.ow_rd_a_data, '0);
      chk("midrst_stall", SR_W'(bus.ow_aux_stall), '0);
      #2 rst = 1'b0;
      tick();
      tick();
      chk("postrst_count", SR_W'(bus.ow_count), '0);
      chk("postrst_rd_b", bus.ow_rd_b_data, '0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
